// File: rtl/guess_scorer.sv
// rtl/guess_scorer.sv - Numberle guess scorer: per-digit green/yellow feedback and game progress
module guess_scorer #(
    parameter int MAX_GUESSES = 6,
    parameter int ATTEMPT_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_game,
    input  logic [15:0]          secret_in,
    input  logic [15:0]          guess_in,
    input  logic                 guess_valid,
    output logic                 busy,
    output logic                 result_valid,
    output logic [3:0]           green,
    output logic [3:0]           yellow,
    output logic [ATTEMPT_W-1:0] attempts,
    output logic                 win,
    output logic                 lose
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_GREEN  = 3'd2;
    localparam logic [2:0] S_YEL    = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_WON    = 3'd5;
    localparam logic [2:0] S_LOST   = 3'd6;

    logic [2:0]           state;
    logic [15:0]          secret;
    logic [15:0]          guess;
    logic [3:0]           used;
    logic [3:0]           g;
    logic [3:0]           y;
    logic [1:0]           idx;
    logic [3:0]           g_cmp;
    logic [3:0]           guess_digit;
    logic                 found;
    logic [1:0]           match_j;
    logic [ATTEMPT_W-1:0] next_attempts;

    assign busy          = (state == S_GREEN) || (state == S_YEL) || (state == S_REPORT);
    assign next_attempts = attempts + 1'b1;
    assign guess_digit   = guess[{idx, 2'b00} +: 4];

    always_comb begin
        g_cmp = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            g_cmp[i] = (guess[4*i +: 4] == secret[4*i +: 4]);
        end
    end

    // Descending scan so the last hit wins, i.e. the lowest unused secret position.
    always_comb begin
        found   = 1'b0;
        match_j = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (!used[j] && (secret[4*j +: 4] == guess_digit)) begin
                found   = 1'b1;
                match_j = j[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            secret       <= 16'h0000;
            guess        <= 16'h0000;
            used         <= 4'b0000;
            g            <= 4'b0000;
            y            <= 4'b0000;
            idx          <= 2'd0;
            result_valid <= 1'b0;
            green        <= 4'b0000;
            yellow       <= 4'b0000;
            attempts     <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (new_game) begin
                secret   <= secret_in;
                attempts <= '0;
                green    <= 4'b0000;
                yellow   <= 4'b0000;
                win      <= 1'b0;
                lose     <= 1'b0;
                state    <= S_READY;
            end else begin
                case (state)
                    S_READY: begin
                        if (guess_valid) begin
                            guess <= guess_in;
                            state <= S_GREEN;
                        end
                    end
                    S_GREEN: begin
                        g     <= g_cmp;
                        used  <= g_cmp;
                        y     <= 4'b0000;
                        idx   <= 2'd0;
                        state <= S_YEL;
                    end
                    S_YEL: begin
                        if (!g[idx] && found) begin
                            y[idx]        <= 1'b1;
                            used[match_j] <= 1'b1;
                        end
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= S_REPORT;
                        end
                    end
                    S_REPORT: begin
                        green        <= g;
                        yellow       <= y;
                        attempts     <= next_attempts;
                        result_valid <= 1'b1;
                        if (g == 4'b1111) begin
                            win   <= 1'b1;
                            state <= S_WON;
                        end else if (next_attempts == ATTEMPT_W'(MAX_GUESSES)) begin
                            lose  <= 1'b1;
                            state <= S_LOST;
                        end else begin
                            state <= S_READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_scorer.sv
// tb/tb_guess_scorer.sv - directed self-checking bench for guess_scorer
module tb_guess_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_game = 1'b0;
    logic [15:0] secret_in = 16'h0000;
    logic [15:0] guess_in = 16'h0000;
    logic        guess_valid = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [3:0]  green;
    logic [3:0]  yellow;
    logic [2:0]  attempts;
    logic        win;
    logic        lose;

    int passed = 0;
    int total  = 0;

    guess_scorer #(.MAX_GUESSES(6), .ATTEMPT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .new_game(new_game),
        .secret_in(secret_in),
        .guess_in(guess_in),
        .guess_valid(guess_valid),
        .busy(busy),
        .result_valid(result_valid),
        .green(green),
        .yellow(yellow),
        .attempts(attempts),
        .win(win),
        .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic start_game(input logic [15:0] s);
        secret_in = s;
        new_game  = 1'b1;
        tick();
        new_game  = 1'b0;
    endtask

    // Returns cycles from guess_valid to result_valid (20 means it never came).
    task automatic do_guess(input logic [15:0] gs, output int lat);
        guess_in    = gs;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        lat = 1;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic pulse_guess(input logic [15:0] gs);
        guess_in    = gs;
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
    endtask

    task automatic watch(input int n, output int rv_cnt, output int busy_cnt);
        rv_cnt   = 0;
        busy_cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (result_valid) rv_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, busy, result_valid, green, yellow, attempts, win, lose};
    endfunction

    initial begin
        int lat;
        int rvc;
        int bc;

        tick();
        tick();
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_outputs", outs(), 32'd0);
        pulse_guess(16'h1234);
        check("idle_guess_ignored_busy", {31'd0, busy}, 32'd0);

        // Exact match
        start_game(16'h1234);
        do_guess(16'h1234, lat);
        check("exact_latency", lat, 7);
        check("exact_green", green, 4'b1111);
        check("exact_yellow", yellow, 4'b0000);
        check("exact_attempts", attempts, 3'd1);
        check("exact_win", {win, lose}, 2'b10);
        tick();
        check("exact_rv_single", {31'd0, result_valid}, 32'd0);
        pulse_guess(16'h1234);
        watch(10, rvc, bc);
        check("won_guess_ignored_rv", rvc, 0);
        check("won_guess_ignored_busy", bc, 0);
        check("won_attempts_hold", attempts, 3'd1);

        // All yellow, then an immediate guess at the earliest READY cycle
        start_game(16'h1234);
        check("newgame_clears", outs(), 32'd0);
        do_guess(16'h4321, lat);
        check("allyel_latency", lat, 7);
        check("allyel_green", green, 4'b0000);
        check("allyel_yellow", yellow, 4'b1111);
        check("allyel_flags", {attempts, win, lose}, {3'd1, 2'b00});
        do_guess(16'h1111, lat);
        check("dup1_latency", lat, 7);
        check("dup1_green", green, 4'b1000);
        check("dup1_yellow", yellow, 4'b0000);
        check("dup1_attempts", attempts, 3'd2);

        start_game(16'h1234);
        do_guess(16'h5511, lat);
        check("dup2_green", green, 4'b0000);
        check("dup2_yellow", yellow, 4'b0001);

        start_game(16'h1123);
        do_guess(16'h1111, lat);
        check("dup3_green", green, 4'b1100);
        check("dup3_yellow", yellow, 4'b0000);

        // Loss after six misses
        start_game(16'h1234);
        for (int i = 1; i <= 6; i++) begin
            do_guess(16'h5678, lat);
            check("loss_latency", lat, 7);
            check("loss_attempts", attempts, i);
            check("loss_lose", {win, lose}, (i == 6) ? 2'b01 : 2'b00);
        end
        pulse_guess(16'h5678);
        watch(10, rvc, bc);
        check("lost_guess_rv", rvc, 0);
        check("lost_attempts_hold", attempts, 3'd6);
        check("lost_sticky", {win, lose}, 2'b01);

        // Second guess_valid while busy is ignored
        start_game(16'h1234);
        pulse_guess(16'h5678);
        tick();
        pulse_guess(16'h1234);
        watch(12, rvc, bc);
        check("busy_guess_single_rv", rvc, 1);
        check("busy_guess_attempts", attempts, 3'd1);
        check("busy_guess_green", green, 4'b0000);
        check("busy_guess_win", win, 1'b0);

        // new_game at T+3 aborts scoring
        pulse_guess(16'h1234);
        tick();
        tick();
        start_game(16'hABCD);
        watch(10, rvc, bc);
        check("abort_no_rv", rvc, 0);
        check("abort_outputs", outs(), 32'd0);
        do_guess(16'hABCD, lat);
        check("abort_then_win_latency", lat, 7);
        check("abort_then_win", {green, win, lose}, {4'b1111, 2'b10});

        // Reset at T+4 mid-scoring
        start_game(16'h1234);
        do_guess(16'h4321, lat);
        check("prerst_yellow", yellow, 4'b1111);
        pulse_guess(16'h1234);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outputs", outs(), 32'd0);
        pulse_guess(16'h1234);
        watch(10, rvc, bc);
        check("midrst_guess_rv", rvc, 0);
        check("midrst_guess_busy", bc, 0);
        start_game(16'h1234);
        do_guess(16'h1234, lat);
        check("after_rst_game", {green, attempts, win}, {4'b1111, 3'd1, 1'b1});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
